// File: rtl/dmem_loader_pkg.sv
// dmem_loader shared types and default widths.
// Imported by the loader, its checksum unit and its interfaces.
package dmem_loader_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;

  typedef enum logic [2:0] {
    LOAD,
    DRAIN,
    CHECK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/dmem_loader_if.sv
// Stream input and data-memory port bundles for dmem_loader.
// master drives the request side, slave answers it.
interface dmem_stream_if #(
  parameter int DATA_W = dmem_loader_pkg::DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready
  );
endinterface

interface dmem_mem_if #(
  parameter int DATA_W = dmem_loader_pkg::DATA_W,
  parameter int ADDR_W = dmem_loader_pkg::ADDR_W
);
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/loader_checksum.sv
// Write-side and read-side modular checksums for dmem_loader.
// match looks at the read sum including the word being added this cycle.
module loader_checksum #(
  parameter int DATA_W = dmem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_add,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_add,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] wsum,
  output logic [DATA_W-1:0] rsum,
  output logic              match
);

  logic [DATA_W-1:0] rsum_next;

  assign rsum_next = rsum + (rd_add ? rd_data : '0);
  assign match     = (wsum == rsum_next);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wsum <= '0;
      rsum <= '0;
    end else if (clr) begin
      wsum <= '0;
      rsum <= '0;
    end else begin
      if (wr_add) wsum <= wsum + wr_data;
      if (rd_add) rsum <= rsum_next;
    end
  end

endmodule

// File: rtl/dmem_loader.sv
// Boot-time data-memory loader: stream in, read back, verify checksum,
// then release the core from reset.
module dmem_loader #(
  parameter int DATA_W = dmem_loader_pkg::DATA_W,
  parameter int ADDR_W = dmem_loader_pkg::ADDR_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  dmem_stream_if.slave      strm,
  dmem_mem_if.master        mem,
  input  logic              reload,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);
  import dmem_loader_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state, state_n;
  logic [ADDR_W:0]   wc_n;
  logic [ADDR_W:0]   rd_cnt, rd_cnt_n;
  logic              ovf_n;
  logic              rdy, rdy_n;
  logic              we, we_n;
  logic              re, re_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [DATA_W-1:0] wdata, wdata_n;
  logic              rvalid;
  logic              hs;
  logic              clr;
  logic              wadd;
  logic              radd;
  logic              match;
  logic [DATA_W-1:0] wsum;
  logic [DATA_W-1:0] rsum;

  assign hs = strm.in_valid & rdy;

  assign strm.in_ready = rdy;
  assign mem.mem_we    = we;
  assign mem.mem_re    = re;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;

  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign core_hold = (state != DONE);

  loader_checksum #(
    .DATA_W (DATA_W)
  ) u_sum (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_add  (wadd),
    .wr_data (strm.in_data),
    .rd_add  (radd),
    .rd_data (mem.mem_rdata),
    .wsum    (wsum),
    .rsum    (rsum),
    .match   (match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= LOAD;
      word_count <= '0;
      overflow   <= 1'b0;
      rd_cnt     <= '0;
      rdy        <= 1'b0;
      we         <= 1'b0;
      re         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      state      <= state_n;
      word_count <= wc_n;
      overflow   <= ovf_n;
      rd_cnt     <= rd_cnt_n;
      rdy        <= rdy_n;
      we         <= we_n;
      re         <= re_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      rvalid     <= re;
    end
  end

  always_comb begin
    state_n  = state;
    wc_n     = word_count;
    ovf_n    = overflow;
    rd_cnt_n = rd_cnt;
    we_n     = 1'b0;
    re_n     = 1'b0;
    addr_n   = addr;
    wdata_n  = wdata;
    clr      = 1'b0;
    wadd     = 1'b0;
    radd     = 1'b0;
    unique case (state)
      LOAD: begin
        if (hs) begin
          we_n    = 1'b1;
          addr_n  = word_count[ADDR_W-1:0];
          wdata_n = strm.in_data;
          wc_n    = word_count + 1'b1;
          wadd    = 1'b1;
          if (strm.in_last) begin
            state_n = DRAIN;
          end else if (wc_n == DEPTH_C) begin
            ovf_n   = 1'b1;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        rd_cnt_n = '0;
        state_n  = CHECK;
      end
      CHECK: begin
        radd = rvalid;
        if (rd_cnt < word_count) begin
          re_n     = 1'b1;
          addr_n   = rd_cnt[ADDR_W-1:0];
          rd_cnt_n = rd_cnt + 1'b1;
        end else if (!re) begin
          // last read data is on mem_rdata now; match includes it
          state_n = (match && !overflow) ? DONE : ERR;
        end
      end
      DONE, ERR: begin
        if (reload) begin
          state_n = LOAD;
          wc_n    = '0;
          ovf_n   = 1'b0;
          clr     = 1'b1;
        end
      end
      default: state_n = LOAD;
    endcase
  end

  assign rdy_n = (state_n == LOAD) && (wc_n < DEPTH_C);

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader with a behavioural data memory.
module tb_dmem_loader;

  localparam int DW    = 64;
  localparam int AW    = 10;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reload = 1'b0;
  logic          core_hold;
  logic          done;
  logic          error;
  logic          overflow;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  dmem_stream_if #(.DATA_W(DW)) strm ();
  dmem_mem_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

  dmem_loader #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .strm       (strm.slave),
    .mem        (mem.master),
    .reload     (reload),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .overflow   (overflow),
    .word_count (word_count)
  );

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          corrupt = 1'b0;
  int            nwr = 0;
  int            nrd = 0;
  int            nboth = 0;

  always @(posedge clk) begin
    if (mem.mem_we) begin
      ram[mem.mem_addr] <= mem.mem_wdata;
      nwr <= nwr + 1;
    end
    if (mem.mem_re) begin
      mem.mem_rdata <= (corrupt && mem.mem_addr == 2) ? 64'd8
                                                       : ram[mem.mem_addr];
      nrd <= nrd + 1;
    end
    if (mem.mem_we && mem.mem_re) nboth <= nboth + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  logic [63:0] img [0:7];

  task automatic push(input logic [63:0] d, input logic l);
    logic r;
    int t;
    t = 0;
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    strm.in_last  = l;
    forever begin
      @(negedge clk);
      r = strm.in_ready;
      @(posedge clk);
      #1;
      if (r) break;
      t++;
      if (t > 50) begin
        check("push_ready", r, 1'b1);
        break;
      end
    end
    strm.in_valid = 1'b0;
    strm.in_last  = 1'b0;
  endtask

  task automatic load(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      push(img[i], i == n - 1);
      if (gap && i < n - 1) begin
        check("wr_on", mem.mem_we, 1'b1);
        @(posedge clk);
        #1;
        check("gap_we", mem.mem_we, 1'b0);
      end
    end
  endtask

  task automatic wait_res(input int w, input bit ok);
    repeat (w + 2) @(posedge clk);
    #1;
    check("pre_done", done, 1'b0);
    check("pre_err", error, 1'b0);
    @(posedge clk);
    #1;
    check("done", done, ok);
    check("error", error, !ok);
    check("hold", core_hold, !ok);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
    check("rl_wc", word_count, 0);
    check("rl_done", done, 1'b0);
    check("rl_err", error, 1'b0);
    check("rl_hold", core_hold, 1'b1);
    check("rl_ovf", overflow, 1'b0);
  endtask

  task automatic check_ram(input int n);
    for (int i = 0; i < n; i++) check($sformatf("ram%0d", i), ram[i], img[i]);
  endtask

  int w0;
  int r0;

  initial begin
    strm.in_valid = 1'b0;
    strm.in_data  = '0;
    strm.in_last  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", strm.in_ready, 1'b0);
    check("rst_we", mem.mem_we, 1'b0);
    check("rst_re", mem.mem_re, 1'b0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_wdata", mem.mem_wdata, 0);
    check("rst_hold", core_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", error, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_wc", word_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rdy_up", strm.in_ready, 1'b1);

    // basic back-to-back load
    img = '{64'd5, 64'd3, 64'd9, 64'd1, 64'd7, 64'd0, 64'd0, 64'd0};
    w0 = nwr;
    r0 = nrd;
    load(5, 1'b0);
    check("b_wc", word_count, 5);
    wait_res(5, 1'b1);
    check("b_wsum", dut.u_sum.wsum, 25);
    check("b_rsum", dut.u_sum.rsum, 25);
    check_ram(5);
    check("b_nwr", nwr - w0, 5);
    check("b_nrd", nrd - r0, 5);

    // gapped stream
    pulse_reload();
    w0 = nwr;
    load(5, 1'b1);
    wait_res(5, 1'b1);
    check_ram(5);
    check("g_nwr", nwr - w0, 5);
    check("g_wc", word_count, 5);

    // corrupted read-back of address 2
    pulse_reload();
    corrupt = 1'b1;
    load(5, 1'b0);
    wait_res(5, 1'b0);
    check("c_rsum", dut.u_sum.rsum, 24);
    check("c_wsum", dut.u_sum.wsum, 25);
    corrupt = 1'b0;

    // overflow: DEPTH words then a ninth that must stall
    pulse_reload();
    for (int i = 0; i < 8; i++) img[i] = 64'(11 + i);
    w0 = nwr;
    for (int i = 0; i < 8; i++) push(img[i], 1'b0);
    check("o_rdy", strm.in_ready, 1'b0);
    check("o_ovf", overflow, 1'b1);
    check("o_wc", word_count, 8);
    strm.in_valid = 1'b1;
    strm.in_data  = 64'd99;
    wait_res(8, 1'b0);
    check("o_rdy2", strm.in_ready, 1'b0);
    check("o_wc2", word_count, 8);
    check("o_ovf2", overflow, 1'b1);
    check("o_nwr", nwr - w0, 8);
    check_ram(8);
    strm.in_valid = 1'b0;

    // single all-ones word
    pulse_reload();
    img[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    r0 = nrd;
    load(1, 1'b0);
    check("s_wc", word_count, 1);
    wait_res(1, 1'b1);
    check("s_nrd", nrd - r0, 1);
    check_ram(1);

    // asynchronous reset mid-load, then a full load
    pulse_reload();
    img = '{64'd5, 64'd3, 64'd9, 64'd1, 64'd7, 64'd0, 64'd0, 64'd0};
    for (int i = 0; i < 3; i++) push(img[i], 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_hold", core_hold, 1'b1);
    check("ar_rdy", strm.in_ready, 1'b0);
    check("ar_wc", word_count, 0);
    check("ar_we", mem.mem_we, 1'b0);
    check("ar_addr", mem.mem_addr, 0);
    check("ar_wdata", mem.mem_wdata, 0);
    check("ar_ovf", overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    load(5, 1'b0);
    wait_res(5, 1'b1);
    check("ar_wc2", word_count, 5);
    check_ram(5);

    // reload from DONE with a two-word image
    pulse_reload();
    img[0] = 64'h10;
    img[1] = 64'h20;
    load(2, 1'b0);
    check("r_wc", word_count, 2);
    wait_res(2, 1'b1);
    check("r_wsum", dut.u_sum.wsum, 64'h30);
    check_ram(2);

    check("we_re_excl", nboth, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
